muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller for the 5-stage MIPS pipeline, sitting beside the EX stage and owning the HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EX, computes products and quotients one bit per cycle, and raises a stall request that the hazard detection logic ORs into PC_Stall, IF_ID_Stall and Control_Mux. The stall is raised whenever the decode-stage instruction touches HI/LO while the unit is busy.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH
- CLK  in  1  clock, all state updates on rising edge
- RST_n  in  1  reset; synchronous and active-low
- ID_EX_Start  in  1  ID/EX holds a valid HI/LO-class instruction this cycle
- ID_EX_Funct  in  6  MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011; other codes ignored
- ID_EX_A  in  WIDTH  rs operand (dividend / multiplicand / MTx source)
- ID_EX_B  in  WIDTH  rt operand (divisor / multiplier)
- IF_ID_OP  in  6  decode-stage opcode
- IF_ID_Funct  in  6  decode-stage funct
- MD_Stall  out  1  combinational stall request to hazard unit
- Busy  out  1  state != IDLE
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation
- FSM: IDLE, RUN, FIN
- IDLE + ID_EX_Start + MULT/MULTU/DIV/DIVU: latch |A|, |B| (absolute value for signed ops, raw for unsigned), result sign, op kind; cnt <= 0; go RUN
- IDLE + ID_EX_Start + MTHI/MTLO: HI (or LO) <= ID_EX_A next edge; stay IDLE
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; cnt increments; at cnt == WIDTH-1, go FIN
- FIN: apply sign correction, write HI/LO, go IDLE
- Multiply: 64-bit product mod 2^64; negated if signed and operand signs differ; HI = upper, LO = lower
- Divide: LO = quotient, HI = remainder; signed: quotient negated if signs differ, remainder takes the dividend's sign
- Divide by zero (both signednesses): LO = 32'hFFFFFFFF, HI = ID_EX_A as latched; no sign correction
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural wrap)
- ID_EX_Start while Busy: ignored; the stall prevents it and no state changes
- MD_Stall = (Busy || (ID_EX_Start && ID_EX_Funct is MULT/MULTU/DIV/DIVU)) && IF_ID is R-type with funct in {MFHI 010000, MFLO 010010, MTHI, MTLO, MULT, MULTU, DIV, DIVU}
- Reset: state IDLE, cnt 0, HI = LO = 0, Busy = 0, MD_Stall = 0 (given non-HI/LO decode); an in-flight operation is discarded

## Timing
- Start sampled at edge E0; RUN covers edges E1..E32; FIN writes HI/LO at E33
- Busy is high for 33 cycles after E0; new HI/LO are visible in the cycle after E33
- MTHI/MTLO: one-edge latency, no stall
- MD_Stall is combinational, with no register stage, so the hazard unit sees it in the same cycle
- MFHI in ID during the Start cycle stalls immediately, in that cycle, not one later
- Reset low at any edge, including RUN/FIN, takes priority over everything; FIN's HI/LO write is suppressed

## Structure
- Shared package/header mips_defs: funct constants (MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU) and R_Type opcode, shared with the hazard and control units
- Sub-module md_iter_core: holds the operand, accumulator and remainder registers and performs one multiply or divide step per enable
- FSM, counter, sign logic and stall decode stay in muldiv_sequencer

## Test plan
- MULT A=-3 (0xFFFFFFFD), B=7 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high for exactly 33 cycles
- DIVU A=100, B=7 -> LO=14, HI=2; DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF
- DIV A=5, B=0 -> LO=0xFFFFFFFF, HI=5; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0
- MULTU in EX with MFLO in ID in the same cycle -> MD_Stall=1 that cycle and through FIN; it drops the cycle after HI/LO are written
- MTLO A=0x1234 while IDLE -> LO=0x1234 next cycle; MD_Stall stays 0
- MULT started, RST_n low at RUN cnt=10 -> next cycle IDLE, HI=LO=0, Busy=0; a subsequent MULT 6*7 gives LO=42

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS decode constants for the HI/LO unit, hazard unit and control unit.
// Also holds the multiply/divide sequencer state type and small decode helpers.
package mips_defs;

  localparam logic [5:0] OP_R_TYPE   = 6'b000000;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  // True when a decode-stage instruction reads or writes HI/LO.
  function automatic logic uses_hilo(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_R_TYPE) &&
           (is_muldiv(funct) || (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO) ||
            (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO));
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Pipeline-side connection of the multiply/divide sequencer.
// ID_EX_Start is a valid-only strobe: it is taken when the unit is idle; while
// Busy, MD_Stall holds the producer off, and a Start seen then is dropped.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             ID_EX_Start;
  logic [5:0]       ID_EX_Funct;
  logic [WIDTH-1:0] ID_EX_A;
  logic [WIDTH-1:0] ID_EX_B;
  logic [5:0]       IF_ID_OP;
  logic [5:0]       IF_ID_Funct;
  logic             MD_Stall;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output ID_EX_Start, ID_EX_Funct, ID_EX_A, ID_EX_B, IF_ID_OP, IF_ID_Funct,
    input  MD_Stall, Busy, HI, LO
  );

  modport slave (
    input  ID_EX_Start, ID_EX_Funct, ID_EX_A, ID_EX_B, IF_ID_OP, IF_ID_Funct,
    output MD_Stall, Busy, HI, LO
  );
endinterface

// File: rtl/md_iter_core.sv
// One-bit-per-step datapath: shift-add multiply or restoring divide on unsigned
// magnitudes. {hi, lo} ends as the product, or as {remainder, quotient}.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The partial remainder is shifted one bit wider, so the borrow of the trial
  // subtract decides the quotient bit.
  always_comb begin
    add_sum = {1'b0, hi} + (lo[0] ? {1'b0, op_b} : '0);
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, op_b};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_b <= '0;
      hi   <= '0;
      lo   <= '0;
    end else if (load) begin
      op_b <= b;
      hi   <= '0;
      lo   <= a;
    end else if (step) begin
      if (!is_div) begin
        hi <= add_sum[WIDTH:1];
        lo <= {add_sum[0], lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        hi <= diff[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi <= shifted[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner beside EX: sequences iterative MULT/MULTU/DIV/DIVU, handles
// MTHI/MTLO and raises the combinational HI/LO stall for the hazard unit.
module muldiv_sequencer
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  muldiv_sequencer_if.slave    md,
  output md_state_t            state_dbg
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             load, step, busy;
  logic             op_div, neg_q, neg_r, div_zero;
  logic [WIDTH-1:0] a_raw, hi_q, lo_q;
  logic [WIDTH-1:0] core_hi, core_lo, abs_a, abs_b, fin_hi, fin_lo;
  logic             op_signed;
  logic             accept;

  assign accept    = md.ID_EX_Start && is_muldiv(md.ID_EX_Funct);
  assign op_signed = (md.ID_EX_Funct == FUNCT_MULT) || (md.ID_EX_Funct == FUNCT_DIV);
  assign abs_a     = (op_signed && md.ID_EX_A[WIDTH-1]) ? -md.ID_EX_A : md.ID_EX_A;
  assign abs_b     = (op_signed && md.ID_EX_B[WIDTH-1]) ? -md.ID_EX_B : md.ID_EX_B;

  always_ff @(posedge CLK) begin
    if (!RST_n) state <= MD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      MD_IDLE: if (accept) begin
        load     = 1'b1;
        state_nx = MD_RUN;
      end
      MD_RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nx = MD_FIN;
      end
      MD_FIN:  state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  // Divide by zero bypasses sign correction and returns the raw dividend.
  always_comb begin
    fin_hi = core_hi;
    fin_lo = core_lo;
    if (!op_div) begin
      if (neg_q) {fin_hi, fin_lo} = -{core_hi, core_lo};
    end else if (div_zero) begin
      fin_hi = a_raw;
      fin_lo = '1;
    end else begin
      if (neg_q) fin_lo = -core_lo;
      if (neg_r) fin_hi = -core_hi;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (load) begin
        cnt      <= '0;
        op_div   <= (md.ID_EX_Funct == FUNCT_DIV) || (md.ID_EX_Funct == FUNCT_DIVU);
        neg_q    <= op_signed && (md.ID_EX_A[WIDTH-1] ^ md.ID_EX_B[WIDTH-1]);
        neg_r    <= op_signed && md.ID_EX_A[WIDTH-1];
        div_zero <= (md.ID_EX_B == '0);
        a_raw    <= md.ID_EX_A;
      end else if (step) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == MD_IDLE && md.ID_EX_Start && md.ID_EX_Funct == FUNCT_MTHI) hi_q <= md.ID_EX_A;
      if (state == MD_IDLE && md.ID_EX_Start && md.ID_EX_Funct == FUNCT_MTLO) lo_q <= md.ID_EX_A;
      if (state == MD_FIN) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (CLK),
    .rst_n  (RST_n),
    .load   (load),
    .step   (step),
    .is_div (op_div),
    .a      (abs_a),
    .b      (abs_b),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  assign busy        = (state != MD_IDLE);
  assign md.Busy     = busy;
  assign md.HI       = hi_q;
  assign md.LO       = lo_q;
  assign md.MD_Stall = (busy || accept) && uses_hilo(md.IF_ID_OP, md.IF_ID_Funct);
  assign state_dbg   = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic reference model with a
// result queue, per-cycle output compare, and literal checks on known vectors.
module tb_muldiv_sequencer;
  import mips_defs::*;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI = 6'b010001, F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

  logic      CLK = 1'b0;
  logic      RST_n = 1'b0;
  md_state_t state_dbg;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .md        (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [63:0] exp_q[$];
  int          busy_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic logic tb_is_md(input logic [5:0] f);
    return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
  endfunction

  function automatic logic tb_hazard(input logic [5:0] op, input logic [5:0] f);
    return op == 6'd0 && (tb_is_md(f) || f == F_MFHI || f == F_MFLO || f == F_MTHI || f == F_MTLO);
  endfunction

  function automatic logic [63:0] exp_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (f == F_DIV) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  always @(posedge CLK) begin
    if (!RST_n) begin
      busy_left = 0;
      m_hi = '0;
      m_lo = '0;
      exp_q.delete();
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) {m_hi, m_lo} = exp_q.pop_front();
    end else if (bus.ID_EX_Start) begin
      if (tb_is_md(bus.ID_EX_Funct)) begin
        exp_q.push_back(exp_result(bus.ID_EX_Funct, bus.ID_EX_A, bus.ID_EX_B));
        busy_left = 33;
      end else if (bus.ID_EX_Funct == F_MTHI) m_hi = bus.ID_EX_A;
      else if (bus.ID_EX_Funct == F_MTLO) m_lo = bus.ID_EX_A;
    end
  end

  // scoreboard: every output, every cycle
  always @(negedge CLK) begin
    if (check_en) begin
      chk("busy", {63'd0, bus.Busy}, {63'd0, busy_left > 0});
      chk("hi", {32'd0, bus.HI}, {32'd0, m_hi});
      chk("lo", {32'd0, bus.LO}, {32'd0, m_lo});
      chk("stall", {63'd0, bus.MD_Stall},
          {63'd0, (busy_left > 0 || (bus.ID_EX_Start && tb_is_md(bus.ID_EX_Funct))) &&
                  tb_hazard(bus.IF_ID_OP, bus.IF_ID_Funct)});
    end
  end

  // driver tasks
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #2;
    bus.ID_EX_Start = 1'b1;
    bus.ID_EX_Funct = f;
    bus.ID_EX_A     = a;
    bus.ID_EX_B     = b;
    @(posedge CLK); #2;
    bus.ID_EX_Start = 1'b0;
  endtask

  task automatic wait_idle(output int busy_cycles, output int stall_cycles);
    busy_cycles  = 0;
    stall_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!bus.Busy) break;
      busy_cycles++;
      if (bus.MD_Stall) stall_cycles++;
    end
    if (bus.Busy) begin
      total++;
      bad++;
      $display("FAIL wait_idle: Busy still 1 after 100 cycles");
    end
  endtask

  logic [5:0]  t_f[6]  = '{F_MULT, F_DIV, F_DIVU, F_MULTU, F_DIVU, F_DIV};
  logic [31:0] t_a[6]  = '{32'hFFFF_FFFB, 32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5, 32'd0};
  logic [31:0] t_b[6]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd10, 32'h8000_0000, 32'd0, 32'd9};
  logic [31:0] t_hi[6] = '{32'd0, 32'd1, 32'd5, 32'h4000_0000, 32'd5, 32'd0};
  logic [31:0] t_lo[6] = '{32'h1E, 32'hFFFF_FFFD, 32'h1999_9999, 32'd0, 32'hFFFF_FFFF, 32'd0};

  initial begin
    int bc, sc;
    bus.ID_EX_Start = 1'b0;
    bus.ID_EX_Funct = 6'd0;
    bus.ID_EX_A     = '0;
    bus.ID_EX_B     = '0;
    bus.IF_ID_OP    = 6'h08;
    bus.IF_ID_Funct = 6'd0;

    @(posedge CLK); #2;
    check_en = 1'b1;
    @(posedge CLK); #2;
    RST_n = 1'b1;
    @(negedge CLK);
    chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
    chk("reset_hi", {32'd0, bus.HI}, 64'd0);
    chk("reset_lo", {32'd0, bus.LO}, 64'd0);
    chk("reset_stall", {63'd0, bus.MD_Stall}, 64'd0);

    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle(bc, sc);
    chk("mult_busy_cycles", 64'(bc), 64'd33);
    chk("mult_hi", {32'd0, bus.HI}, 64'hFFFF_FFFF);
    chk("mult_lo", {32'd0, bus.LO}, 64'hFFFF_FFEB);

    // a second Start arriving while busy must be dropped
    issue(F_DIVU, 32'd100, 32'd7);
    bus.ID_EX_Start = 1'b1;
    bus.ID_EX_Funct = F_MTHI;
    bus.ID_EX_A     = 32'hDEAD;
    @(posedge CLK); #2;
    bus.ID_EX_Start = 1'b0;
    wait_idle(bc, sc);
    chk("divu_lo", {32'd0, bus.LO}, 64'd14);
    chk("divu_hi", {32'd0, bus.HI}, 64'd2);

    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(bc, sc);
    chk("div_neg_lo", {32'd0, bus.LO}, 64'hFFFF_FFFD);
    chk("div_neg_hi", {32'd0, bus.HI}, 64'hFFFF_FFFF);

    issue(F_DIV, 32'd5, 32'd0);
    wait_idle(bc, sc);
    chk("div0_lo", {32'd0, bus.LO}, 64'hFFFF_FFFF);
    chk("div0_hi", {32'd0, bus.HI}, 64'd5);

    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(bc, sc);
    chk("ovf_lo", {32'd0, bus.LO}, 64'h8000_0000);
    chk("ovf_hi", {32'd0, bus.HI}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      issue(t_f[i], t_a[i], t_b[i]);
      wait_idle(bc, sc);
      chk($sformatf("table%0d_hi", i), {32'd0, bus.HI}, {32'd0, t_hi[i]});
      chk($sformatf("table%0d_lo", i), {32'd0, bus.LO}, {32'd0, t_lo[i]});
    end

    // MTLO with MFHI in decode: one-edge write, never a stall
    @(posedge CLK); #2;
    bus.IF_ID_OP    = 6'd0;
    bus.IF_ID_Funct = F_MFHI;
    bus.ID_EX_Start = 1'b1;
    bus.ID_EX_Funct = F_MTLO;
    bus.ID_EX_A     = 32'h1234;
    @(negedge CLK);
    chk("mtlo_stall", {63'd0, bus.MD_Stall}, 64'd0);
    @(posedge CLK); #2;
    bus.ID_EX_Start = 1'b0;
    @(negedge CLK);
    chk("mtlo_lo", {32'd0, bus.LO}, 64'h1234);
    chk("mtlo_busy", {63'd0, bus.Busy}, 64'd0);

    // MULTU with MFLO in decode: stall from the Start cycle through FIN
    @(posedge CLK); #2;
    bus.IF_ID_Funct = F_MFLO;
    bus.ID_EX_Start = 1'b1;
    bus.ID_EX_Funct = F_MULTU;
    bus.ID_EX_A     = 32'hFFFF_FFFF;
    bus.ID_EX_B     = 32'd2;
    @(negedge CLK);
    chk("stall_start_cycle", {63'd0, bus.MD_Stall}, 64'd1);
    @(posedge CLK); #2;
    bus.ID_EX_Start = 1'b0;
    wait_idle(bc, sc);
    chk("stall_busy_cycles", 64'(sc), 64'd33);
    chk("stall_after", {63'd0, bus.MD_Stall}, 64'd0);
    chk("multu_hi", {32'd0, bus.HI}, 64'd1);
    chk("multu_lo", {32'd0, bus.LO}, 64'hFFFF_FFFE);

    // reset in RUN at cnt == 10 discards the operation
    bus.IF_ID_OP = 6'h08;
    issue(F_MULT, 32'd3, 32'd5);
    repeat (10) @(posedge CLK);
    #2;
    RST_n = 1'b0;
    @(posedge CLK); #2;
    RST_n = 1'b1;
    @(negedge CLK);
    chk("rst_run_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_run_hi", {32'd0, bus.HI}, 64'd0);
    chk("rst_run_lo", {32'd0, bus.LO}, 64'd0);

    issue(F_MULT, 32'd6, 32'd7);
    wait_idle(bc, sc);
    chk("after_rst_lo", {32'd0, bus.LO}, 64'd42);
    chk("after_rst_hi", {32'd0, bus.HI}, 64'd0);

    @(posedge CLK); #2;
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
